// File: rtl/fma_pkg.sv
// Shared FP16 constants, accumulator scaling and FSM state type for the FMA datapath.
package fma_pkg;

   localparam int          FP16_BIAS      = 15;
   localparam logic [15:0] FP16_POS_INF   = 16'h7C00;
   localparam logic [15:0] FP16_NEG_INF   = 16'hFC00;
   localparam logic [15:0] FP16_ZERO      = 16'h0000;

   // Accumulator LSB weight is 2^-ACC_LSB_OFFSET.
   localparam int          ACC_LSB_OFFSET = 26;

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      NORM = 2'd1,
      RND  = 2'd2,
      OUT  = 2'd3
   } acc_state_t;

   // Round-to-nearest-even increment decision.
   function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
      return guard & (sticky | lsb);
   endfunction

endpackage

// File: rtl/int_fp_accum_lzc.sv
// Leading-one locator over W bits: returns the index of the highest set bit and an all-zero flag.
module lzc #(
   parameter int W  = 58,
   parameter int PW = $clog2(W)
) (
   input  logic [W-1:0]  din,
   output logic [PW-1:0] pos,
   output logic          zero
);

   // Scan upward so the highest set bit wins.
   always_comb begin
      pos  = {PW{1'b0}};
      zero = ~|din;
      for (int i = 0; i < W; i++) begin
         pos = din[i] ? PW'(i) : pos;
      end
   end

endmodule

// File: rtl/int_fp_accum.sv
// Fixed-point dot-product accumulator with FP16 normalise/round output stage.
// Optional feature: ACC_CNT_LIMIT_EN forces termination at MAX_LEN products and adds out_trunc.
module int_fp_accum
   import fma_pkg::*;
#(
   parameter int ACC_W   = 58,
   parameter int MAX_LEN = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [4:0]  in_exp,
   input  logic [18:0] in_man,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data
`ifdef ACC_CNT_LIMIT_EN
   ,
   output logic        out_trunc
`endif
);

   localparam int PW     = $clog2(ACC_W);
   localparam int CNT_W  = $clog2(MAX_LEN + 1);
   // Leading-one index p maps to biased exponent p - P_BIAS.
   localparam int P_BIAS = ACC_LSB_OFFSET - FP16_BIAS;

   acc_state_t       state_r;
   logic [ACC_W-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;

   logic             hs_s;
   logic             last_s;
   logic [4:0]       sh_s;
   logic [49:0]      aligned_s;
   logic [ACC_W-1:0] addend_s;

   logic [ACC_W-1:0] mag_s;
   logic [PW-1:0]    p_s;
   logic             zero_s;
   logic [PW-1:0]    norm_sh_s;
   logic [10:0]      top11_s;
   logic [ACC_W-1:0] sticky_mask_s;
   logic             sticky_s;

   logic             sgn_r;
   logic             zero_r;
   logic             under_r;
   logic             over_r;
   logic [4:0]       exp_r;
   logic [9:0]       mant_r;
   logic             guard_r;
   logic             sticky_r;

   logic             rnd_up_s;
   logic [10:0]      mant_sum_s;
   logic [5:0]       exp_sum_s;
   logic [15:0]      res_s;

`ifdef ACC_CNT_LIMIT_EN
   logic             force_s;
   logic             trunc_pend_r;
`endif

   assign in_ready = (state_r == ACC) && !reset;
   assign hs_s     = in_valid && in_ready;

   // Align the product to the accumulator grid and apply its sign.
   always_comb begin
      // in_exp + 16 for a 5-bit two's-complement value is just an MSB flip.
      sh_s      = {~in_exp[4], in_exp[3:0]};
      aligned_s = {31'd0, in_man} << sh_s;
      if (in_sign) begin
         addend_s = -{{(ACC_W-50){1'b0}}, aligned_s};
      end else begin
         addend_s = {{(ACC_W-50){1'b0}}, aligned_s};
      end
   end

`ifdef ACC_CNT_LIMIT_EN
   assign force_s = (cnt_r == CNT_W'(MAX_LEN - 1));
   assign last_s  = in_last || force_s;
`else
   assign last_s  = in_last;
`endif

   assign mag_s = acc_r[ACC_W-1] ? -acc_r : acc_r;

   lzc #(
      .W  (ACC_W),
      .PW (PW)
   ) u_lzc (
      .din  (mag_s),
      .pos  (p_s),
      .zero (zero_s)
   );

   // Extract leading one, 10 mantissa bits and guard; everything lower folds into sticky.
   always_comb begin
      if (p_s >= PW'(P_BIAS)) begin
         norm_sh_s = p_s - PW'(P_BIAS);
      end else begin
         norm_sh_s = {PW{1'b0}};
      end
      top11_s       = 11'(mag_s >> norm_sh_s);
      sticky_mask_s = ({{(ACC_W-1){1'b0}}, 1'b1} << norm_sh_s) - {{(ACC_W-1){1'b0}}, 1'b1};
      sticky_s      = |(mag_s & sticky_mask_s);
   end

   // Round and pack; a mantissa carry bumps the exponent and may overflow to infinity.
   always_comb begin
      rnd_up_s   = rne_up(mant_r[0], guard_r, sticky_r);
      mant_sum_s = {1'b0, mant_r} + {10'd0, rnd_up_s};
      exp_sum_s  = {1'b0, exp_r} + {5'd0, mant_sum_s[10]};
      res_s      = FP16_ZERO;
      if (zero_r) begin
         res_s = FP16_ZERO;
      end else if (under_r) begin
         res_s = {sgn_r, 15'd0};
      end else if (over_r || (exp_sum_s >= 6'd31)) begin
         res_s = sgn_r ? FP16_NEG_INF : FP16_POS_INF;
      end else if (mant_sum_s[10]) begin
         res_s = {sgn_r, exp_sum_s[4:0], 10'd0};
      end else begin
         res_s = {sgn_r, exp_sum_s[4:0], mant_sum_s[9:0]};
      end
   end

   // Normalisation pipeline register, captured in NORM.
   always_ff @(posedge clk) begin
      if (reset) begin
         sgn_r    <= 1'b0;
         zero_r   <= 1'b0;
         under_r  <= 1'b0;
         over_r   <= 1'b0;
         exp_r    <= 5'd0;
         mant_r   <= 10'd0;
         guard_r  <= 1'b0;
         sticky_r <= 1'b0;
      end else if (state_r == NORM) begin
         sgn_r    <= acc_r[ACC_W-1];
         zero_r   <= zero_s;
         under_r  <= (p_s < PW'(P_BIAS + 1));
         over_r   <= (p_s > PW'(P_BIAS + 30));
         exp_r    <= 5'(p_s - PW'(P_BIAS));
         mant_r   <= top11_s[10:1];
         guard_r  <= top11_s[0];
         sticky_r <= sticky_s;
      end
   end

   // Control FSM, accumulator, length counter and output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ACC;
         acc_r        <= {ACC_W{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         out_valid    <= 1'b0;
         out_data     <= FP16_ZERO;
`ifdef ACC_CNT_LIMIT_EN
         out_trunc    <= 1'b0;
         trunc_pend_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            ACC: begin
               if (hs_s) begin
                  acc_r <= acc_r + addend_s;
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (last_s) begin
                     state_r <= NORM;
                  end
`ifdef ACC_CNT_LIMIT_EN
                  trunc_pend_r <= force_s && !in_last;
`endif
               end
            end
            NORM: begin
               state_r <= RND;
            end
            RND: begin
               out_data <= res_s;
               state_r  <= OUT;
            end
            OUT: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
`ifdef ACC_CNT_LIMIT_EN
                  out_trunc <= trunc_pend_r;
`endif
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  acc_r     <= {ACC_W{1'b0}};
                  cnt_r     <= {CNT_W{1'b0}};
                  state_r   <= ACC;
`ifdef ACC_CNT_LIMIT_EN
                  out_trunc <= 1'b0;
`endif
               end
            end
            default: begin
               state_r <= ACC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_fp_accum.sv
// Directed self-checking bench for int_fp_accum; covers ACC_CNT_LIMIT_EN when that macro is defined.
module tb_int_fp_accum;

`ifdef ACC_CNT_LIMIT_EN
   localparam int TB_MAX_LEN = 4;
`else
   localparam int TB_MAX_LEN = 64;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [4:0]  in_exp;
   logic [18:0] in_man;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
`ifdef ACC_CNT_LIMIT_EN
   logic        out_trunc;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   int_fp_accum #(
      .ACC_W   (58),
      .MAX_LEN (TB_MAX_LEN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_man    (in_man),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef ACC_CNT_LIMIT_EN
      ,
      .out_trunc (out_trunc)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Present one product; it is accepted at the next rising edge.
   task automatic send(input logic s, input logic [4:0] e, input logic [18:0] m, input logic l);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_man   = m;
      in_last  = l;
      chk("in_ready_at_send", {15'd0, in_ready}, 16'h0001);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called right after the accepting edge; out_valid must rise exactly three edges later.
   task automatic expect_result(input string tag, input logic [15:0] expd, input bit take);
      @(posedge clk); #1;
      chk({tag, "_lat1"}, {15'd0, out_valid}, 16'h0000);
      @(posedge clk); #1;
      chk({tag, "_lat2"}, {15'd0, out_valid}, 16'h0000);
      @(posedge clk); #1;
      chk({tag, "_valid"}, {15'd0, out_valid}, 16'h0001);
      chk({tag, "_data"}, out_data, expd);
      if (take) begin
         @(posedge clk); #1;
         chk({tag, "_taken"}, {15'd0, out_valid}, 16'h0000);
         chk({tag, "_ready_after"}, {15'd0, in_ready}, 16'h0001);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 5'd0;
      in_man    = 19'd0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {15'd0, in_ready}, 16'h0000);
      chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
      chk("rst_out_data", out_data, 16'h0000);
`ifdef ACC_CNT_LIMIT_EN
      chk("rst_out_trunc", {15'd0, out_trunc}, 16'h0000);
`endif
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", {15'd0, in_ready}, 16'h0001);

      send(1'b0, 5'd0, 19'd1024, 1'b1);
      expect_result("single_one", 16'h3C00, 1'b1);

      send(1'b1, 5'd0, 19'd1024, 1'b1);
      expect_result("neg_one", 16'hBC00, 1'b1);

      send(1'b0, 5'd0, 19'd1024, 1'b0);
      send(1'b1, 5'd0, 19'd1024, 1'b1);
      expect_result("cancel", 16'h0000, 1'b1);

      send(1'b0, 5'd0, 19'd1024, 1'b0);
      send(1'b0, 5'd0, 19'd1024, 1'b0);
      send(1'b0, 5'd0, 19'd1024, 1'b1);
      expect_result("accum3", 16'h4200, 1'b1);

      send(1'b0, 5'd0, 19'd2049, 1'b1);
      expect_result("rne_tie_even", 16'h4000, 1'b1);

      send(1'b0, 5'd0, 19'd2051, 1'b1);
      expect_result("rne_tie_up", 16'h4002, 1'b1);

      send(1'b0, 5'd0, 19'd4095, 1'b1);
      expect_result("rnd_carry", 16'h4400, 1'b1);

      send(1'b0, 5'd14, 19'd4094, 1'b1);
      expect_result("max_finite", 16'h7BFF, 1'b1);

      send(1'b0, 5'd14, 19'd4095, 1'b1);
      expect_result("carry_to_inf", 16'h7C00, 1'b1);

      send(1'b0, 5'd15, 19'd521985, 1'b1);
      expect_result("ovf_pos", 16'h7C00, 1'b1);

      send(1'b1, 5'd15, 19'd521985, 1'b1);
      expect_result("ovf_neg", 16'hFC00, 1'b1);

      // exp -4 and -5: exactly min normal, and one binade below it.
      send(1'b0, 5'b11100, 19'd1, 1'b1);
      expect_result("min_normal", 16'h0400, 1'b1);

      send(1'b0, 5'b11011, 19'd1, 1'b1);
      expect_result("flush_pos", 16'h0000, 1'b1);

      send(1'b0, 5'b10000, 19'd1, 1'b1);
      expect_result("udf_exp_m16", 16'h0000, 1'b1);

      send(1'b1, 5'b10000, 19'd1, 1'b1);
      expect_result("flush_neg", 16'h8000, 1'b1);

      out_ready = 1'b0;
      send(1'b0, 5'd0, 19'd1024, 1'b1);
      expect_result("bp", 16'h3C00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {15'd0, out_valid}, 16'h0001);
         chk("bp_hold_data", out_data, 16'h3C00);
         chk("bp_in_ready_low", {15'd0, in_ready}, 16'h0000);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_taken", {15'd0, out_valid}, 16'h0000);
      chk("bp_ready_after", {15'd0, in_ready}, 16'h0001);

      // Partial sum 3.0 is sitting in NORM when reset hits.
      send(1'b0, 5'd0, 19'd1024, 1'b0);
      send(1'b0, 5'd0, 19'd2048, 1'b1);
      reset = 1'b1;
      #1;
      chk("rst_norm_in_ready", {15'd0, in_ready}, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("rst_norm_out_valid", {15'd0, out_valid}, 16'h0000);
      chk("rst_norm_in_ready_back", {15'd0, in_ready}, 16'h0001);
      send(1'b0, 5'd0, 19'd1024, 1'b1);
      expect_result("post_rst", 16'h3C00, 1'b1);

`ifdef ACC_CNT_LIMIT_EN
      send(1'b0, 5'd0, 19'd1024, 1'b0);
      send(1'b0, 5'd0, 19'd1024, 1'b0);
      send(1'b0, 5'd0, 19'd1024, 1'b0);
      send(1'b0, 5'd0, 19'd1024, 1'b0);
      expect_result("cnt_limit", 16'h4400, 1'b0);
      chk("cnt_limit_trunc", {15'd0, out_trunc}, 16'h0001);
      @(posedge clk); #1;
      chk("cnt_limit_taken", {15'd0, out_valid}, 16'h0000);
      chk("cnt_limit_trunc_clr", {15'd0, out_trunc}, 16'h0000);
      send(1'b0, 5'd0, 19'd1024, 1'b1);
      expect_result("after_limit", 16'h3C00, 1'b0);
      chk("after_limit_trunc", {15'd0, out_trunc}, 16'h0000);
      @(posedge clk); #1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/int_fp_accum.md
# int_fp_accum

Accumulates the signed fixed-point products from the INT8×FP16 multiplier stage over one dot product. The products arrive as sign, unbiased exponent and 19-bit mantissa. On the last product the block normalises and rounds the sum to one FP16 result. It sits directly downstream of the multiplier in the FMA datapath and feeds the FP16 writeback/output buffer through a valid/ready handshake.

## Interface
- ACC_W, 58: signed accumulator width in bits; LSB weight is 2^-26.
- MAX_LEN, 64: maximum products per dot product; sizes the length counter.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  product available.
- in_ready  out  1  `(state==ACC) && !reset`.
- in_sign  in  1  product sign, 1 = negative.
- in_exp  in  5  signed two's-complement unbiased activation exponent, -16..15.
- in_man  in  19  unsigned product magnitude.
- in_last  in  1  marks the final product of the dot product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  FP16 result.

## Operation
- The product value is (-1)^in_sign · in_man · 2^(in_exp-10).
- Alignment: `aligned = in_man << (in_exp + 16)`, with a shift of 0..31 and a 50-bit result.
  - The aligned value is negated when in_sign=1, then sign-extended to ACC_W.
- A handshake is in_valid && in_ready. On a handshake the block sets `acc <= acc + aligned` and `cnt <= cnt + 1`.
- There is no special handling of exponent codes. in_exp=-16 is numeric.
- FSM states: ACC, NORM, RND, OUT.
  - ACC → NORM on a handshake with in_last=1. Otherwise it stays in ACC.
  - NORM → RND unconditionally. In NORM:
    - register `mag=|acc|` and `sgn=acc[ACC_W-1]`;
    - compute the leading-one position p of mag through the `lzc` sub-module;
    - register the 10 mantissa bits below p, the guard bit (p-11), and the sticky bit (OR of bits below p-11).
  - RND → OUT unconditionally. RND rounds round-to-nearest-even and builds out_data.
  - OUT → ACC when out_ready=1. Leaving OUT clears acc and cnt to 0.
- Exponent and result rules:
  - Biased exponent = p - 11.
  - mag=0 gives 0x0000, always +0 and never -0.
  - p<12 (below min normal) flushes to ±0 with the sign of sgn. Subnormals are never produced.
  - p>41, or a rounding carry that raises the biased exponent to 31, gives ±inf (0x7C00 / 0xFC00).
  - A mantissa rounding carry increments the exponent and clears the mantissa.
- The accumulator never wraps for MAX_LEN products of the maximum magnitude. Behaviour beyond MAX_LEN products is undefined unless ACC_CNT_LIMIT_EN is defined.

## Timing
- Reset values:
  - state=ACC, acc=0, cnt=0;
  - out_valid=0, out_data=16'h0000;
  - in_ready=0 while reset is high.
- Accumulation throughput: one product per cycle, with no bubbles between non-last products.
- Latency: if in_last is accepted at edge k, out_valid is high after edge k+3 (NORM at k+1, RND at k+2, OUT at k+3).
  - The earliest next product is accepted at the edge after the result is taken.
- out_data is stable while out_valid=1 and out_ready=0, and is held indefinitely.
- in_ready=0 in NORM, RND and OUT. Products are not lost; the upstream stage stalls.
- Reset mid-operation (any state) returns to the reset values on the next edge. A partial sum is discarded.

## Configuration
- ACC_CNT_LIMIT_EN defined:
  - a handshake with cnt==MAX_LEN-1 is treated as last even if in_last=0;
  - an extra output `out_trunc` (1 bit, reset 0) is high with out_valid when termination was forced rather than driven by in_last.
- ACC_CNT_LIMIT_EN undefined: only in_last terminates, and there is no out_trunc port.

## Structure
- Package `fma_pkg` holds:
  - FP16 constants: bias 15, `FP16_POS_INF`=16'h7C00, `FP16_NEG_INF`=16'hFC00, `FP16_ZERO`;
  - the LSB offset 26;
  - the FSM state enum `acc_state_t`.
- Sub-module `lzc`: a parameterised leading-zero counter over ACC_W bits that returns p and an all-zero flag. The counter is combinational, used once inside NORM.

## Test plan
- Single product: man=1024, exp=0, sign=0, last=1 → out_data=0x3C00, out_valid exactly 3 edges after the accepting edge.
- Cancellation: (man=1024, exp=0, +) then (1024, 0, -, last) → 0x0000.
- Accumulation: three products of (1024, 0, +), back-to-back, last on the third → 0x4200, no in_ready gaps.
- RNE rounding:
  - (2049, 0, +, last) → 0x4000 (tie to even);
  - (2051, 0, +, last) → 0x4002.
- Overflow and underflow:
  - (521985, 15, +, last) → 0x7C00; the same with sign=1 → 0xFC00;
  - (1, -16, +, last) → 0x0000.
- Backpressure and reset:
  - out_ready low for 5 cycles → out_data held and in_ready low;
  - reset asserted while in NORM → the next result reflects only post-reset products;
  - with ACC_CNT_LIMIT_EN, MAX_LEN=4 and 4 products with no last → result valid and out_trunc=1.
